// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: operation codes, FSM encoding,
// shift direction and small decode helpers.
package alu_pkg;

  localparam int unsigned CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_SLL = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SRL = 3'b111;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } alu_state_e;

  // Shifts are the only multi-cycle operations.
  function automatic logic is_shift(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

  function automatic logic shift_dir(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SRL) ? SHIFT_RIGHT : SHIFT_LEFT;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: loads on start, shifts while the counter is
// non-zero, and flags done_c in the cycle whose shift is the final one.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dir,
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(WIDTH)-1:0]   amount,
  output logic [WIDTH-1:0]           shifted_c,
  output logic                       done_c,
  output logic                       busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             dir_q;

  // Value after this cycle's single-bit shift; zero fill in both directions.
  always_comb begin
    shifted_c = work;
    if (dir_q == SHIFT_RIGHT) begin
      shifted_c = work >> 1;
    end else begin
      shifted_c = work << 1;
    end
  end

  assign done_c = (cnt == SHW'(1));
  assign busy   = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      cnt   <= '0;
      dir_q <= SHIFT_LEFT;
    end else if (start) begin
      work  <= data;
      cnt   <= amount;
      dir_q <= dir;
    end else if (cnt != '0) begin
      work <= shifted_c;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle arithmetic/logic
// ops and a serial shifter for sll/srl, results held until consumed.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   ALUControl,
  input  logic [WIDTH-1:0]    SrcA,
  input  logic [WIDTH-1:0]    SrcB,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    ALUResult,
  output logic                Zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e        state;
  alu_state_e        state_next;
  logic              out_valid_next;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              shift_start;
  logic              accept;
  logic [SHW-1:0]    shamt;
  logic [WIDTH-1:0]  alu_c;
  logic [WIDTH-1:0]  shifted_c;
  logic              shift_done_c;
  logic              shift_busy;

  // A drained HOLD can take a new op on the same edge.
  assign in_ready = rst_n && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = SrcB[SHW-1:0];

  // Single-cycle datapath; a zero-amount shift passes SrcA through.
  always_comb begin
    alu_c = SrcA;
    case (ALUControl)
      ALU_ADD: alu_c = SrcA + SrcB;
      ALU_SUB: alu_c = SrcA - SrcB;
      ALU_OR:  alu_c = SrcA | SrcB;
      ALU_AND: alu_c = SrcA & SrcB;
      ALU_XOR: alu_c = SrcA ^ SrcB;
      ALU_SLT: alu_c = WIDTH'($signed(SrcA) < $signed(SrcB));
      default: alu_c = SrcA;
    endcase
  end

  alu_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (shift_start),
    .dir       (shift_dir(ALUControl)),
    .data      (SrcA),
    .amount    (shamt),
    .shifted_c (shifted_c),
    .done_c    (shift_done_c),
    .busy      (shift_busy)
  );

  // Handshake FSM: next state, result load and shifter kick-off.
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid;
    load           = 1'b0;
    load_val       = alu_c;
    shift_start    = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if ((state == ST_HOLD) && out_ready) begin
          state_next     = ST_IDLE;
          out_valid_next = 1'b0;
        end
        if (accept) begin
          if (is_shift(ALUControl) && (shamt != '0)) begin
            shift_start    = 1'b1;
            state_next     = ST_SHIFT;
            out_valid_next = 1'b0;
          end else begin
            load           = 1'b1;
            load_val       = alu_c;
            state_next     = ST_HOLD;
            out_valid_next = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_done_c) begin
          load           = 1'b1;
          load_val       = shifted_c;
          state_next     = ST_HOLD;
          out_valid_next = 1'b1;
        end else if (!shift_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= out_valid_next;
      if (load) begin
        ALUResult <= load_val;
        Zero      <= (load_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: single-cycle ops, serial shifts,
// back-to-back throughput, backpressure and reset during a shift.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one op at a negedge, then count stall cycles until out_valid.
  task automatic do_op(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int stall;
    int rdy_low;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    stall   = 0;
    rdy_low = 0;
    @(negedge clk);
    while (!out_valid && stall < 100) begin
      stall++;
      if (!in_ready) rdy_low++;
      @(negedge clk);
    end
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "_rdy_low"}, 32'(rdy_low), 32'(exp_stall));
    check({tag, "_result"}, ALUResult, exp_res);
    check({tag, "_zero"}, 32'(Zero), 32'(exp_res == 32'd0));
  endtask

  logic [2:0]  b2b_ctrl [3] = '{3'b011, 3'b010, 3'b100};
  logic [31:0] b2b_a    [3] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000};
  logic [31:0] b2b_b    [3] = '{32'h0FF0_FF00, 32'h0000_000F, 32'hFF00_FF00};
  logic [31:0] b2b_exp  [3] = '{32'h00F0_1200, 32'hF000_000F, 32'h00FF_FF00};

  initial begin
    int seen;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", 32'(Zero), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 32'(in_ready), 32'd1);

    do_op("add",     3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 0);
    do_op("sub",     3'b001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 0);
    do_op("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
    do_op("slt_pos", 3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op("sll4",    3'b110, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 4);
    do_op("srl31",   3'b111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 31);
    do_op("sll0",    3'b110, 32'h0000_ABCD, 32'h0000_0020, 32'h0000_ABCD, 0);
    do_op("srl4",    3'b111, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 4);

    // Back-to-back with in_valid held: one result per cycle, in order.
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      ALUControl = b2b_ctrl[i];
      SrcA       = b2b_a[i];
      SrcB       = b2b_b[i];
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_result", ALUResult, b2b_exp[i]);
    end
    in_valid = 1'b0;

    // Backpressure: result must stay frozen while out_ready is low.
    @(negedge clk);
    out_ready  = 1'b0;
    ALUControl = 3'b000;
    SrcA       = 32'h0000_0010;
    SrcB       = 32'h0000_0020;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", ALUResult, 32'h0000_0030);
    end
    ALUControl = 3'b001;
    SrcA       = 32'h0000_0030;
    SrcB       = 32'h0000_0031;
    in_valid   = 1'b1;
    #1 check("bp_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 check("bp_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", 32'(out_valid), 32'd1);
    check("bp_new_result", ALUResult, 32'hFFFF_FFFF);
    check("bp_new_zero", 32'(Zero), 32'd0);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset two cycles into a 10-bit shift abandons it.
    ALUControl = 3'b110;
    SrcA       = 32'h0000_0003;
    SrcB       = 32'h0000_000A;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", ALUResult, 32'd0);
    check("mid_rst_zero", 32'(Zero), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_ghost_result", 32'(seen), 32'd0);
    do_op("post_rst_add", 3'b000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execute-stage ALU for the RISC-V core; consumes the 3-bit `ALUControl` code produced by the ALU decoder, plus the two operands, and returns a registered result and `Zero` flag to the writeback/branch logic.
- Single-cycle ops complete in one cycle.
- Shifts use an area-light serial shifter: one bit per cycle under a small FSM.
- valid/ready handshakes on both sides allow stalling.

## Interface
- `WIDTH`, 32, operand/result width; must be a power of two ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept an operation this cycle.
- `ALUControl`  in  3  operation code: 000 add, 001 sub, 010 or, 011 and, 100 xor, 101 slt, 110 sll, 111 srl.
- `SrcA`  in  WIDTH  first operand.
- `SrcB`  in  WIDTH  second operand; for shifts, low log2(WIDTH) bits are the shift amount.
- `out_valid`  out  1  `ALUResult`/`Zero` valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `ALUResult`  out  WIDTH  registered result.
- `Zero`  out  1  registered, = (`ALUResult` == 0).

## Operation
- **FSM states:**
  - IDLE: accepting.
  - SHIFT: serial shift in progress.
  - HOLD: result valid, waiting for `out_ready`.
- **Accept:** an operation is accepted on a clock edge where `in_valid && in_ready`; `ALUControl`, `SrcA` and `SrcB` are sampled only then.
- **`in_ready`:** `in_ready = rst_n && (state==IDLE || (state==HOLD && out_ready))`, so the output can drain and a new op be accepted in the same cycle.
- **Non-shift ops (000–101):** result computed combinationally at accept, registered, state → HOLD.
- **Arithmetic:**
  - add and sub are modulo 2^WIDTH; carry and overflow are discarded.
  - xor/or/and are bitwise.
  - slt compares signed: result = {WIDTH-1 zeros, $signed(SrcA) < $signed(SrcB)}.
- **Shift ops (110 sll, 111 srl):**
  - `shamt` = SrcB[log2(WIDTH)-1:0]; the upper SrcB bits are ignored.
  - srl is logical (zero fill).
  - If `shamt`==0: result = SrcA, state → HOLD directly.
  - Else: working register ← SrcA, counter ← `shamt`, state → SHIFT.
  - Each SHIFT cycle shifts the working register by 1 and decrements the counter.
  - On the cycle the counter reaches 1, the shifted value is loaded into `ALUResult` and state → HOLD.
- **HOLD:**
  - `out_valid`=1; `ALUResult` and `Zero` are stable until the edge where `out_ready`=1.
  - On that edge, state → IDLE, or reloads (HOLD/SHIFT) if a new op is accepted the same edge.
- **SHIFT state:** `in_ready`=0 and `out_valid`=0.

## Timing
- **Reset values:** state IDLE, `out_valid`=0, `ALUResult`=0, `Zero`=0, shift counter 0; `in_ready`=0 while `rst_n` low, 1 the first cycle after release.
- **Latency from accept edge to `out_valid`:**
  - Non-shift: 1 cycle.
  - Shift with `shamt`=n: n cycles (n≥1), 1 cycle for n=0.
  - Worst case: WIDTH-1 cycles.
- **Throughput:** one non-shift op per cycle when `out_ready` is held high.
- **Backpressure:** `out_valid`, `ALUResult` and `Zero` must not change while `out_valid && !out_ready`.
- **Reset asserted mid-SHIFT or in HOLD:** the operation is abandoned, no result is emitted, all outputs go to reset values immediately (asynchronous).
- **`in_valid` while `in_ready`=0:** ignored; the upstream stage must hold its inputs.

## Structure
- **Package `alu_pkg`:**
  - ALUControl localparams: `ALU_ADD`, `ALU_SUB`, `ALU_OR`, `ALU_AND`, `ALU_XOR`, `ALU_SLT`, `ALU_SLL`, `ALU_SRL`.
  - FSM state encoding.
  - The ALU decoder is updated to import the same constants.
- **Sub-module `alu_serial_shifter`:** working register, down-counter, direction, `start`/`done`. The top level owns the handshake FSM and the single-cycle datapath.

## Test plan
- Reset then add 0x0000_0005 + 0x0000_0003, `out_ready`=1 → `out_valid` one cycle after accept, `ALUResult`=0x0000_0008, `Zero`=0.
- sub 0x7 − 0x7 → `ALUResult`=0, `Zero`=1. slt 0xFFFF_FFFF vs 0x1 → 1. slt 0x1 vs 0xFFFF_FFFF → 0.
- sll 0x0000_0001 by SrcB=0xFFFF_FFE4 (`shamt` 4) → `in_ready` low 4 cycles, `ALUResult`=0x0000_0010 after 4 cycles. srl 0x8000_0000 by 31 → 0x0000_0001 after 31 cycles. Shift by 0 → 1-cycle latency, result = SrcA.
- Back-to-back and, or, xor with `out_ready`=1 and `in_valid` held → one result per cycle, in order, values correct.
- Hold `out_ready`=0 for 5 cycles after a result → `in_ready`=0, outputs stable. Raise `out_ready` with `in_valid`=1 → drain and accept on the same edge.
- Assert `rst_n` low 2 cycles into a 10-bit shift → `out_valid`, `ALUResult` and `Zero` go to 0 immediately, no result after release, next op behaves normally.
